// File: rtl/control_sequencer.sv
// control_sequencer: two-cycle fetch/execute control unit for the datapath.
// Owns the 6-bit PC and the 16-bit IR. It decodes IR into the datapath
// controls and into the memory write strobe. Conditional branches use the
// Z flag from the datapath.
// Optional feature: define CONTROL_SEQUENCER_STEP_EN to add a `step` input
// and a WAIT state. With the macro defined, the sequencer pauses after
// every non-HALT instruction until step is seen high.
module control_sequencer #(
    parameter logic [3:0] FS_ADD   = 4'h0,
    parameter logic [3:0] FS_PASSA = 4'hF
) (
    input  logic        clk_main,
    input  logic        reset,
`ifdef CONTROL_SEQUENCER_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] MemData,
    input  logic        Z,
    output logic [5:0]  PC,
    output logic [3:0]  DR,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [3:0]  FS,
    output logic        MB,
    output logic        MM,
    output logic        MD,
    output logic        RW,
    output logic        MW,
    output logic        halted
);

`ifdef CONTROL_SEQUENCER_STEP_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;
    localparam state_t EXEC_NEXT = S_WAIT;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;
    localparam state_t EXEC_NEXT = S_FETCH;
`endif

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  op;
    logic [5:0]  br_off;
    logic [5:0]  jmp_tgt;

    // Instruction fields. The branch offset is {DR,SB} and the jump target
    // is {SA,SB}; both are truncated to the 6-bit address space.
    assign op      = ir_q[15:12];
    assign br_off  = {ir_q[9:8], ir_q[3:0]};
    assign jmp_tgt = ir_q[5:0];

    assign PC = pc_q;
    assign DR = ir_q[11:8];
    assign SA = ir_q[7:4];
    assign SB = ir_q[3:0];

    // State, PC and IR registers. Async reset returns to FETCH at address 0.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= 6'd0;
            ir_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next state, PC/IR update and decoded datapath controls.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        FS      = 4'h0;
        MB      = 1'b0;
        MM      = 1'b1;
        MD      = 1'b0;
        RW      = 1'b0;
        MW      = 1'b0;
        halted  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // MM=1 by default, so MemData holds the word at PC.
                ir_d    = MemData;
                pc_d    = pc_q + 6'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = EXEC_NEXT;
                case (op)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        FS = {1'b0, op[2:0]};
                        RW = 1'b1;
                    end
                    4'h8: begin
                        FS = FS_ADD;
                        MB = 1'b1;
                        RW = 1'b1;
                    end
                    4'h9: begin
                        MM = 1'b0;
                        MD = 1'b1;
                        RW = 1'b1;
                    end
                    4'hA: begin
                        MM = 1'b0;
                        MW = 1'b1;
                    end
                    4'hB: begin
                        FS = FS_PASSA;
                        if (Z) pc_d = pc_q + br_off;
                    end
                    4'hC: begin
                        FS = FS_PASSA;
                        if (!Z) pc_d = pc_q + br_off;
                    end
                    4'hD: begin
                        pc_d = jmp_tgt;
                    end
                    4'hF: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        // NOP: all controls stay at their defaults.
                    end
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef CONTROL_SEQUENCER_STEP_EN
            S_WAIT: begin
                if (step) state_d = S_FETCH;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Writes are blocked while reset is asserted. This prevents a
        // partial write from an aborted EXEC cycle.
        if (reset) begin
            RW = 1'b0;
            MW = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed program walk-through plus randomized
// instruction streams, compared every cycle against an instruction-level
// behavioural model.
module tb_control_sequencer;

    localparam logic [3:0] FS_ADD   = 4'h0;
    localparam logic [3:0] FS_PASSA = 4'hF;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] MemData;
    logic        Z        = 1'b0;
`ifdef CONTROL_SEQUENCER_STEP_EN
    logic        step     = 1'b1;
`endif
    logic [5:0]  PC;
    logic [3:0]  DR, SA, SB, FS;
    logic        MB, MM, MD, RW, MW, halted;

    logic [15:0] mem [64];
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;

    always #5 clk_main = ~clk_main;

    // Single shared memory with asynchronous read. The data read is only
    // used when the PC addresses it; other reads return filler.
    assign MemData = MM ? mem[PC] : 16'h5A5A;

    control_sequencer #(.FS_ADD(FS_ADD), .FS_PASSA(FS_PASSA)) dut (
        .clk_main (clk_main),
        .reset    (reset),
`ifdef CONTROL_SEQUENCER_STEP_EN
        .step     (step),
`endif
        .MemData  (MemData),
        .Z        (Z),
        .PC       (PC),
        .DR       (DR),
        .SA       (SA),
        .SB       (SB),
        .FS       (FS),
        .MB       (MB),
        .MM       (MM),
        .MD       (MD),
        .RW       (RW),
        .MW       (MW),
        .halted   (halted)
    );

    // ---------------- instruction-level reference model ----------------
    typedef enum int {PH_FETCH, PH_EXEC, PH_HALT, PH_WAIT} phase_e;
`ifdef CONTROL_SEQUENCER_STEP_EN
    localparam phase_e AFTER_EXEC = PH_WAIT;
`else
    localparam phase_e AFTER_EXEC = PH_FETCH;
`endif

    logic [5:0]  m_pc;
    logic [15:0] m_ir;
    phase_e      m_ph;

    always @(posedge clk_main or posedge reset) begin
        if (reset) begin
            m_pc <= 6'd0;
            m_ir <= 16'd0;
            m_ph <= PH_FETCH;
        end else begin
            case (m_ph)
                PH_FETCH: begin
                    m_ir <= mem[m_pc];
                    m_pc <= 6'((32'(m_pc) + 1) % 64);
                    m_ph <= PH_EXEC;
                end
                PH_EXEC: begin
                    m_ph <= (m_ir[15:12] == 4'hF) ? PH_HALT : AFTER_EXEC;
                    if ((m_ir[15:12] == 4'hB && Z) || (m_ir[15:12] == 4'hC && !Z))
                        m_pc <= 6'((32'(m_pc) + 32'(m_ir[9:8]) * 16 + 32'(m_ir[3:0])) % 64);
                    else if (m_ir[15:12] == 4'hD)
                        m_pc <= m_ir[5:0];
                end
`ifdef CONTROL_SEQUENCER_STEP_EN
                PH_WAIT: if (step) m_ph <= PH_FETCH;
`endif
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic [5:0] pc;
        logic [3:0] dr, sa, sb, fs;
        logic       mb, mm, md, rw, mw, hl;
    } outs_t;

    function automatic outs_t model_outs(input logic [5:0] pc, input logic [15:0] ir,
                                         input phase_e ph, input logic rst);
        outs_t o;
        o    = '0;
        o.pc = pc;
        o.dr = ir[11:8];
        o.sa = ir[7:4];
        o.sb = ir[3:0];
        o.mm = 1'b1;
        if (ph == PH_EXEC && !rst) begin
            if (ir[15:12] < 4'h8) begin
                o.fs = ir[15:12];
                o.rw = 1'b1;
            end else begin
                case (ir[15:12])
                    4'h8: begin o.fs = FS_ADD; o.mb = 1'b1; o.rw = 1'b1; end
                    4'h9: begin o.mm = 1'b0; o.md = 1'b1; o.rw = 1'b1; end
                    4'hA: begin o.mm = 1'b0; o.mw = 1'b1; end
                    4'hB, 4'hC: o.fs = FS_PASSA;
                    default: ;
                endcase
            end
        end
        if (ph == PH_HALT) o.hl = 1'b1;
        return o;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        outs_t e;
        forever begin
            @(negedge clk_main);
            if (cmp_en) begin
                e = model_outs(m_pc, m_ir, m_ph, reset);
                chk("pc",     16'(PC),     16'(e.pc));
                chk("dr",     16'(DR),     16'(e.dr));
                chk("sa",     16'(SA),     16'(e.sa));
                chk("sb",     16'(SB),     16'(e.sb));
                chk("fs",     16'(FS),     16'(e.fs));
                chk("mb",     16'(MB),     16'(e.mb));
                chk("mm",     16'(MM),     16'(e.mm));
                chk("md",     16'(MD),     16'(e.md));
                chk("rw",     16'(RW),     16'(e.rw));
                chk("mw",     16'(MW),     16'(e.mw));
                chk("halted", 16'(halted), 16'(e.hl));
                chk("rw_mw_excl", 16'(RW & MW), 16'd0);
            end
        end
    end

    // Watchdog: the run is a fixed number of clocks, so this only fires on a hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk_main);
        #1;
    endtask

    // Reset asserted and released mid-cycle; the caller continues in the
    // first FETCH cycle at negedge+3.
    task automatic do_reset();
        @(negedge clk_main);
        #2 reset = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk_main);
        #2 reset = 1'b0;
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 64; i++) mem[i] = 16'hE000;
    endtask

    initial begin
`ifndef CONTROL_SEQUENCER_STEP_EN
        // ---- program 1: ADDI, ALU, ST, LD, BZ taken, JMP, JMP wrap, HALT ----
        fill_nop();
        mem[0]  = 16'h8105;
        mem[1]  = 16'h0212;
        mem[2]  = 16'hA013;
        mem[3]  = 16'h9403;
        mem[4]  = 16'hB0F3;
        mem[8]  = 16'hD03E;
        mem[62] = 16'hD03F;
        mem[63] = 16'hF000;
        do_reset();
        chk("c1_pc", 16'(PC), 16'd0);
        chk("c1_mm", 16'(MM), 16'd1);
        chk("c1_rw", 16'(RW), 16'd0);
        chk("c1_halted", 16'(halted), 16'd0);
        tick();
        chk("addi_pc", 16'(PC), 16'd1);
        chk("addi_rw", 16'(RW), 16'd1);
        chk("addi_mb", 16'(MB), 16'd1);
        chk("addi_fs", 16'(FS), 16'(FS_ADD));
        chk("addi_dr", 16'(DR), 16'd1);
        tick(); tick();
        chk("alu_fs", 16'(FS), 16'h0);
        chk("alu_mb", 16'(MB), 16'd0);
        chk("alu_md", 16'(MD), 16'd0);
        chk("alu_rw", 16'(RW), 16'd1);
        chk("alu_regs", {4'h0, DR, SA, SB}, 16'h0212);
        tick(); tick();
        chk("st_mw", 16'(MW), 16'd1);
        chk("st_mm", 16'(MM), 16'd0);
        chk("st_rw", 16'(RW), 16'd0);
        tick(); tick();
        chk("ld_md", 16'(MD), 16'd1);
        chk("ld_mm", 16'(MM), 16'd0);
        chk("ld_rw", 16'(RW), 16'd1);
        chk("ld_dr", 16'(DR), 16'd4);
        tick();
        chk("bz_fetch_pc", 16'(PC), 16'd4);
        Z = 1'b1;
        tick();
        chk("bz_fs", 16'(FS), 16'(FS_PASSA));
        chk("bz_rw", 16'(RW), 16'd0);
        tick();
        chk("bz_taken_pc", 16'(PC), 16'd8);
        tick(); tick();
        chk("jmp_pc62", 16'(PC), 16'd62);
        tick(); tick();
        chk("jmp_pc63", 16'(PC), 16'd63);
        tick();
        chk("wrap_pc0", 16'(PC), 16'd0);
        chk("halt_exec_halted", 16'(halted), 16'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_halted", 16'(halted), 16'd1);
            chk("halt_pc", 16'(PC), 16'd0);
            chk("halt_rw", 16'(RW), 16'd0);
            chk("halt_mw", 16'(MW), 16'd0);
        end

        // ---- program 2: backward branch wrap, not-taken BZ, reset mid-ST ----
        fill_nop();
        mem[0]  = 16'hBFFE;
        mem[63] = 16'hD004;
        mem[4]  = 16'hB0F3;
        mem[5]  = 16'hA013;
        Z = 1'b1;
        do_reset();
        chk("p2_pc0", 16'(PC), 16'd0);
        tick();
        chk("p2_bz_pc", 16'(PC), 16'd1);
        tick();
        chk("bz_back_wrap", 16'(PC), 16'd63);
        tick(); tick();
        chk("p2_jmp_pc4", 16'(PC), 16'd4);
        Z = 1'b0;
        tick(); tick();
        chk("bz_not_taken", 16'(PC), 16'd5);
        tick();
        chk("p2_st_mw", 16'(MW), 16'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mw_drop", 16'(MW), 16'd0);
        chk("rst_rw", 16'(RW), 16'd0);
        chk("rst_pc", 16'(PC), 16'd0);
        chk("rst_mm", 16'(MM), 16'd1);
        chk("rst_regs", {4'h0, DR, SA, SB}, 16'h0000);
        @(negedge clk_main);
        #2 reset = 1'b0;
        #1;
        chk("after_rst_rw", 16'(RW), 16'd0);
        chk("after_rst_pc", 16'(PC), 16'd0);
        tick();
        chk("after_rst_exec_pc", 16'(PC), 16'd1);
        chk("after_rst_exec_fs", 16'(FS), 16'(FS_PASSA));
`endif

        // ---- randomized instruction streams ----
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_main);
            #2;
            Z = 1'($urandom_range(0, 1));
`ifdef CONTROL_SEQUENCER_STEP_EN
            step = 1'($urandom_range(0, 1));
`endif
            if (i % 150 == 149) begin
                reset = 1'b1;
                #2 reset = 1'b0;
                mem[$urandom_range(0, 63)] = 16'($urandom);
            end
        end
        @(negedge clk_main);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
